adc_sdata_responder: RTL and testbench

Serial-ADC emulator: the responder end of the nCS/SDATA link our ADC reader uses to fetch the 8-bit current temperature. Frames a supplied sample value onto SDATA whenever the reader asserts nCS, in the same leading-zeros / MSB-first / trailing-zeros format as the ADC. Used for hardware-in-the-loop plant emulation and loopback testing of the control loop without the real converter.

---
 rtl/adc_sdata_responder.sv | 133 +++++++++++++
 tb/tb_adc_sdata_responder.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/adc_sdata_responder.sv
// Responder side of the nCS/SDATA serial-ADC link: frames a captured sample as
// leading zeros, MSB-first data and trailing zeros while the reader holds nCS low.
module adc_sdata_responder #(
    parameter int FRAME_LEN  = 16,
    parameter int LEAD_ZEROS = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  nCS,
    input  logic [DATA_WIDTH-1:0] sample,
    output logic                  SDATA,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  aborted,
    output logic [15:0]           frame_count,
    output logic [1:0]            state_dbg
);

    localparam int TRAIL_ZEROS = FRAME_LEN - LEAD_ZEROS - DATA_WIDTH;
    localparam int IDX_W       = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    if ((LEAD_ZEROS + DATA_WIDTH > FRAME_LEN) || (FRAME_LEN < 2)) begin : g_bad_params
        $error("adc_sdata_responder: LEAD_ZEROS + DATA_WIDTH must fit in FRAME_LEN (>= 2)");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [FRAME_LEN-1:0]   shreg_q, shreg_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   sdata_q, sdata_d;
    logic                   done_q, done_d;
    logic                   abort_q, abort_d;
    logic [15:0]            frame_count_q, frame_count_d;
    logic                   ncs_prev_q, ncs_prev_d;

    logic [FRAME_LEN-1:0]   frame_img;
    logic                   start;

    // Link protocol: a frame starts on the first clock sampling nCS low after it
    // was sampled high; one bit per clock follows; nCS high before the last bit
    // aborts the frame; a new frame always needs nCS to go high in between.
    always_comb begin
        frame_img = FRAME_LEN'(sample) << TRAIL_ZEROS;
        start     = !nCS && ncs_prev_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            shreg_q       <= '0;
            idx_q         <= '0;
            sdata_q       <= 1'b0;
            done_q        <= 1'b0;
            abort_q       <= 1'b0;
            frame_count_q <= 16'd0;
            ncs_prev_q    <= 1'b1;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            idx_q         <= idx_d;
            sdata_q       <= sdata_d;
            done_q        <= done_d;
            abort_q       <= abort_d;
            frame_count_q <= frame_count_d;
            ncs_prev_q    <= ncs_prev_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        idx_d         = idx_q;
        sdata_d       = 1'b0;
        done_d        = 1'b0;
        abort_d       = 1'b0;
        frame_count_d = frame_count_q;
        ncs_prev_d    = nCS;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sdata_d = frame_img[FRAME_LEN-1];
                    shreg_d = frame_img << 1;
                    idx_d   = IDX_W'(1);
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // The last bit goes out even if nCS rises on the same edge.
                if (idx_q == LAST_IDX) begin
                    sdata_d       = shreg_q[FRAME_LEN-1];
                    shreg_d       = shreg_q << 1;
                    idx_d         = '0;
                    done_d        = 1'b1;
                    frame_count_d = frame_count_q + 16'd1;
                    state_d       = nCS ? ST_IDLE : ST_HOLD;
                end else if (nCS) begin
                    idx_d   = '0;
                    abort_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    sdata_d = shreg_q[FRAME_LEN-1];
                    shreg_d = shreg_q << 1;
                    idx_d   = idx_q + IDX_W'(1);
                end
            end
            ST_HOLD: begin
                if (nCS) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        SDATA       = sdata_q;
        busy        = (state_q == ST_SHIFT);
        frame_done  = done_q;
        aborted     = abort_q;
        frame_count = frame_count_q;
        state_dbg   = state_q;
    end

endmodule

// File: tb/tb_adc_sdata_responder.sv
// Bench for adc_sdata_responder: directed frame table, reset/wrap sequences and
// random nCS bursts checked against a per-burst model of the serial frame.
module tb_adc_sdata_responder;

  localparam int FRAME_LEN  = 16;
  localparam int LEAD_ZEROS = 4;
  localparam int DATA_WIDTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        ncs;
  logic [7:0]  sample;
  logic        sdata;
  logic        busy;
  logic        frame_done;
  logic        aborted;
  logic [15:0] frame_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_count = 16'd0;
  // {sdata, busy, frame_done, aborted, frame_count}
  logic [19:0] exp_q[$];

  typedef struct {
    int         low_len;
    int         high_len;
    logic [7:0] smp;
    logic [7:0] smp_after;
    logic [15:0] exp_stream;
    int         exp_done;
    int         exp_abort;
  } vec_t;

  vec_t vecs[7];

  adc_sdata_responder #(
    .FRAME_LEN (FRAME_LEN),
    .LEAD_ZEROS(LEAD_ZEROS),
    .DATA_WIDTH(DATA_WIDTH)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .nCS        (ncs),
    .sample     (sample),
    .SDATA      (sdata),
    .busy       (busy),
    .frame_done (frame_done),
    .aborted    (aborted),
    .frame_count(frame_count),
    .state_dbg  (state_dbg)
  );

  // clock / watchdog
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic fbit(input logic [7:0] s, input int t);
    if (t >= LEAD_ZEROS && t < LEAD_ZEROS + DATA_WIDTH)
      return s[DATA_WIDTH - 1 - (t - LEAD_ZEROS)];
    return 1'b0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic expect_cycle(input logic sd, input logic b, input logic d, input logic a);
    exp_q.push_back({sd, b, d, a, exp_count});
  endtask

  // one clock: drive, wait edge, compare against the scoreboard head
  task automatic step(input logic n, input logic [7:0] s);
    logic [19:0] e;
    ncs = n;
    sample = s;
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard actual=empty required=entry");
    end else begin
      e = exp_q.pop_front();
      check("flags", {28'd0, sdata, busy, frame_done, aborted}, {28'd0, e[19:16]});
      check("frame_count", {16'd0, frame_count}, {16'd0, e[15:0]});
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_count = 16'd0;
    for (int i = 0; i < 2; i++) begin
      expect_cycle(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b1, 8'($urandom));
    end
    check("reset_state", {30'd0, state_dbg}, 32'd0);
    reset = 1'b0;
  endtask

  // nCS low for low_len clocks then high for high_len clocks; the model predicts
  // the frame from the burst length alone
  task automatic run_frame(input int low_len, input int high_len,
                           input logic [7:0] s, input logic [7:0] s_after,
                           output logic [15:0] stream, output int ndone, output int nab);
    bit complete;
    logic sd, b, d, a;
    complete = (low_len >= FRAME_LEN - 1);
    stream = 16'd0;
    ndone = 0;
    nab = 0;
    for (int t = 0; t < low_len + high_len; t++) begin
      sd = 1'b0; b = 1'b0; d = 1'b0; a = 1'b0;
      if (complete) begin
        if (t < FRAME_LEN) sd = fbit(s, t);
        b = (t < FRAME_LEN - 1);
        d = (t == FRAME_LEN - 1);
        if (d) exp_count = exp_count + 16'd1;
      end else begin
        if (t < low_len) sd = fbit(s, t);
        b = (t < low_len);
        a = (t == low_len);
      end
      expect_cycle(sd, b, d, a);
      step((t < low_len) ? 1'b0 : 1'b1, (t == 0) ? s : s_after);
      if (t < 16) stream[15 - t] = sdata;
      ndone += int'(frame_done);
      nab += int'(aborted);
    end
  endtask

  initial begin
    logic [15:0] stream;
    int nd, na;

    vecs[0] = '{20, 2,  8'hA5, 8'hA5, 16'h0A50, 1, 0};
    vecs[1] = '{6,  12, 8'hFF, 8'hFF, 16'h0C00, 0, 1};
    vecs[2] = '{20, 2,  8'h01, 8'h01, 16'h0010, 1, 0};
    vecs[3] = '{40, 3,  8'h3C, 8'hFF, 16'h03C0, 1, 0};
    vecs[4] = '{15, 3,  8'h81, 8'h00, 16'h0810, 1, 0};
    vecs[5] = '{11, 5,  8'hFF, 8'h00, 16'h0FE0, 0, 1};
    vecs[6] = '{1,  15, 8'h80, 8'h7F, 16'h0000, 0, 1};

    ncs = 1'b1;
    sample = 8'h00;
    do_reset();

    for (int i = 0; i < 7; i++) begin
      run_frame(vecs[i].low_len, vecs[i].high_len, vecs[i].smp, vecs[i].smp_after,
                stream, nd, na);
      check($sformatf("vec%0d_stream", i), {16'd0, stream}, {16'd0, vecs[i].exp_stream});
      check($sformatf("vec%0d_done", i), nd, vecs[i].exp_done);
      check($sformatf("vec%0d_abort", i), na, vecs[i].exp_abort);
    end
    check("table_count", {16'd0, frame_count}, 32'd4);

    // reset while bit 9 is being shifted, then restart with nCS still low
    for (int t = 0; t < 9; t++) begin
      expect_cycle(fbit(8'h5A, t), 1'b1, 1'b0, 1'b0);
      step(1'b0, (t == 0) ? 8'h5A : 8'($urandom));
    end
    reset = 1'b1;
    exp_count = 16'd0;
    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'hC3);
    reset = 1'b0;
    run_frame(20, 2, 8'hC3, 8'h00, stream, nd, na);
    check("post_reset_stream", {16'd0, stream}, 32'h0C30);
    check("post_reset_done", nd, 1);

    for (int r = 0; r < 30; r++) begin
      run_frame($urandom_range(1, 24), $urandom_range(1, 4), 8'($urandom), 8'($urandom),
                stream, nd, na);
    end

    // frame_count wrap
    force dut.frame_count_q = 16'hFFFF;
    exp_count = 16'hFFFF;
    expect_cycle(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h00);
    release dut.frame_count_q;
    run_frame(18, 2, 8'h96, 8'h00, stream, nd, na);
    check("wrap_count", {16'd0, frame_count}, 32'd0);
    check("wrap_stream", {16'd0, stream}, 32'h0960);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
